// File: rtl/seg_fmt_pkg.sv
//------------------------------------------------------------------------------
// seg_fmt_pkg
//   Shared types and constants for the binary-to-7-segment digit formatter.
//   Contents: FSM state encoding, decimal digit segment patterns
//   ({dp,g,f,e,d,c,b,a}, active-high), blank/dash patterns and the
//   value/digit geometry.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seg_fmt_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int VALUE_W    = 27;
  localparam int BCD_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = 5;

  // Largest value that fits in eight decimal digits.
  localparam logic [VALUE_W-1:0] MAX_VALUE = 27'd99_999_999;

  // Shift-counter value while the final double-dabble step runs.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_ENCODE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bcd_to_seg.sv
//------------------------------------------------------------------------------
// bcd_to_seg
//   Combinational decoder: one BCD digit -> 7-segment pattern {dp,g,f,e,d,c,b,a}.
//   dp is always 0. Non-decimal codes decode to blank.
//   Ports:
//     digit_i [3:0]  BCD digit
//     seg_o   [7:0]  segment pattern, active-high
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_to_seg
  import seg_fmt_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_digit_fmt.sv
//------------------------------------------------------------------------------
// seg_digit_fmt
//   Converts a 27-bit unsigned value to eight 7-segment digit patterns using a
//   serial double-dabble (27 cycles) followed by a one-cycle encode. Values
//   above 99,999,999 display dashes on every digit.
//   Optional feature macro: SEG_FMT_BLANK_EN -- leading-zero blanking
//   (oSEG0 is never blanked).
//   Ports:
//     iCLK              clock, rising edge
//     nRST              synchronous active-low reset
//     iVALUE [26:0]     value to display
//     iLOAD             start request, honoured only while idle
//     oSEG7..oSEG0[7:0] segment patterns {dp,g,f,e,d,c,b,a}; oSEG0 = ones digit
//     oBUSY             conversion in progress
//     oDONE             one-cycle pulse when new patterns appear
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_digit_fmt
  import seg_fmt_pkg::*;
(
  input  logic               iCLK,
  input  logic               nRST,
  input  logic [VALUE_W-1:0] iVALUE,
  input  logic               iLOAD,
  output logic [7:0]         oSEG7,
  output logic [7:0]         oSEG6,
  output logic [7:0]         oSEG5,
  output logic [7:0]         oSEG4,
  output logic [7:0]         oSEG3,
  output logic [7:0]         oSEG2,
  output logic [7:0]         oSEG1,
  output logic [7:0]         oSEG0,
  output logic               oBUSY,
  output logic               oDONE
);

  state_e                        state_q, state_d;
  logic [VALUE_W-1:0]            bin_q,   bin_d;
  logic [BCD_W-1:0]              bcd_q,   bcd_d;
  logic [CNT_W-1:0]              cnt_q,   cnt_d;
  logic                          ovf_q,   ovf_d;
  logic                          done_q,  done_d;
  logic [NUM_DIGITS-1:0][7:0]    seg_q,   seg_d;

  logic [BCD_W-1:0]              bcd_adj;
  logic [NUM_DIGITS-1:0][7:0]    digit_seg;
  logic [NUM_DIGITS-1:0][7:0]    disp_seg;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_to_seg u_bcd_to_seg (
      .digit_i (bcd_q[4*gi +: 4]),
      .seg_o   (digit_seg[gi])
    );
  end

`ifdef SEG_FMT_BLANK_EN
  logic lead_zero;

  // Walk from the most-significant digit down; blank zeros until the first
  // nonzero digit. Digit 0 is outside the loop so it is always shown.
  always_comb begin
    disp_seg  = digit_seg;
    lead_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead_zero && (bcd_q[4*i +: 4] == 4'd0)) begin
        disp_seg[i] = SEG_BLANK;
      end else begin
        lead_zero = 1'b0;
      end
    end
  end
`else
  always_comb begin
    disp_seg = digit_seg;
  end
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iLOAD) begin
          bin_d   = iVALUE;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (iVALUE > MAX_VALUE);
          state_d = ST_CONVERT;
        end
      end

      ST_CONVERT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
        bin_d = {bin_q[VALUE_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = ST_ENCODE;
        end
      end

      ST_ENCODE: begin
        // Patterns change only here so the display never shows partial work.
        for (int i = 0; i < NUM_DIGITS; i++) begin
          seg_d[i] = ovf_q ? SEG_DASH : disp_seg[i];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  assign oBUSY = (state_q != ST_IDLE);
  assign oDONE = done_q;

  assign oSEG0 = seg_q[0];
  assign oSEG1 = seg_q[1];
  assign oSEG2 = seg_q[2];
  assign oSEG3 = seg_q[3];
  assign oSEG4 = seg_q[4];
  assign oSEG5 = seg_q[5];
  assign oSEG6 = seg_q[6];
  assign oSEG7 = seg_q[7];

endmodule

`default_nettype wire
